// File: rtl/alarm_siren_ctrl.sv
// Alarm responder: debounced trigger, arm/entry-delay FSM, timed siren and blinking strobe.
// All outputs registered (one enabled edge after the deciding inputs); ena=0 freezes every register.
module alarm_siren_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ENTRY_DELAY     = 16,
  parameter int SIREN_TIME      = 64,
  parameter int BLINK_HALF      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       trig,
  input  logic       arm,
  input  logic       ack,
  output logic [2:0] state_o,
  output logic       siren,
  output logic       strobe,
  output logic       armed,
  output logic [3:0] event_cnt
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DLY_W = $clog2(ENTRY_DELAY + 1);
  localparam int SIR_W = $clog2(SIREN_TIME + 1);
  localparam int BLK_W = $clog2(BLINK_HALF + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(ENTRY_DELAY - 1);
  localparam logic [SIR_W-1:0] SIR_LOAD = SIR_W'(SIREN_TIME - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_ENTRY    = 3'd2,
    ST_ALARM    = 3'd3,
    ST_SILENCED = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             trig_db_q, trig_db_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [SIR_W-1:0] sir_q, sir_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             siren_q, siren_d;
  logic             strobe_q, strobe_d;
  logic             armed_q, armed_d;
  logic [3:0]       cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    trig_db_d = trig_db_q;
    db_cnt_d  = db_cnt_q;
    dly_d     = dly_q;
    sir_d     = sir_q;
    blk_d     = blk_q;
    siren_d   = siren_q;
    strobe_d  = strobe_q;
    armed_d   = armed_q;
    cnt_d     = cnt_q;

    if (ena) begin
      if (trig == trig_db_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        trig_db_d = trig;
        db_cnt_d  = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end

      // The FSM reacts to the filtered level already held, not this cycle's update.
      if (!arm) begin
        state_d = ST_DISARMED;
      end else begin
        case (state_q)
          ST_DISARMED: state_d = ST_ARMED;
          ST_ARMED: begin
            if (trig_db_q) begin
              state_d = ST_ENTRY;
              dly_d   = DLY_LOAD;
            end
          end
          ST_ENTRY: begin
            if (dly_q == '0) begin
              state_d = ST_ALARM;
              sir_d   = SIR_LOAD;
              if (cnt_q != 4'd15) cnt_d = cnt_q + 4'd1;
            end else begin
              dly_d = dly_q - 1'b1;
            end
          end
          ST_ALARM: begin
            if (ack || (sir_q == '0)) state_d = ST_SILENCED;
            else                      sir_d   = sir_q - 1'b1;
          end
          ST_SILENCED: begin
            if (!trig_db_q) state_d = ST_ARMED;
          end
          default: state_d = ST_DISARMED;
        endcase
      end

      siren_d = (state_d == ST_ALARM);
      armed_d = (state_d != ST_DISARMED);
      if (state_d == ST_ALARM) begin
        if (state_q != ST_ALARM) begin
          strobe_d = 1'b1;
          blk_d    = '0;
        end else if (blk_q == BLK_LAST) begin
          strobe_d = ~strobe_q;
          blk_d    = '0;
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end else begin
        strobe_d = (state_d == ST_SILENCED);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_DISARMED;
      trig_db_q <= 1'b0;
      db_cnt_q  <= '0;
      dly_q     <= '0;
      sir_q     <= '0;
      blk_q     <= '0;
      siren_q   <= 1'b0;
      strobe_q  <= 1'b0;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      trig_db_q <= trig_db_d;
      db_cnt_q  <= db_cnt_d;
      dly_q     <= dly_d;
      sir_q     <= sir_d;
      blk_q     <= blk_d;
      siren_q   <= siren_d;
      strobe_q  <= strobe_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign state_o   = state_q;
  assign siren     = siren_q;
  assign strobe    = strobe_q;
  assign armed     = armed_q;
  assign event_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Bench for alarm_siren_ctrl: table of {inputs, repeat count, expected outputs} rows,
// plus hand-written saturation loop and mid-alarm asynchronous reset.
module tb_alarm_siren_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, ena, trig, arm, ack;
  logic [2:0] state_o;
  logic       siren, strobe, armed;
  logic [3:0] event_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    logic       trig, arm, ack, ena;
    int         reps;
    logic [2:0] st;
    logic       siren, strobe, armed;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  alarm_siren_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .trig(trig), .arm(arm), .ack(ack),
    .state_o(state_o), .siren(siren), .strobe(strobe), .armed(armed),
    .event_cnt(event_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic t, logic a, logic k, logic e, int r,
                              logic [2:0] st, logic si, logic so, logic ar, logic [3:0] c);
    vec_t x;
    x.name = n; x.trig = t; x.arm = a; x.ack = k; x.ena = e; x.reps = r;
    x.st = st; x.siren = si; x.strobe = so; x.armed = ar; x.cnt = c;
    return x;
  endfunction

  task automatic chk(string nm, string fld, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
    end
  endtask

  task automatic cmp_outputs(vec_t e);
    chk(e.name, "state_o",   int'(state_o),   int'(e.st));
    chk(e.name, "siren",     int'(siren),     int'(e.siren));
    chk(e.name, "strobe",    int'(strobe),    int'(e.strobe));
    chk(e.name, "armed",     int'(armed),     int'(e.armed));
    chk(e.name, "event_cnt", int'(event_cnt), int'(e.cnt));
  endtask

  // Called at a falling edge; drives the row for 'reps' rising edges and checks after the last one.
  task automatic apply_row(vec_t v);
    vec_t e;
    for (int r = 0; r < v.reps; r++) begin
      trig = v.trig; arm = v.arm; ack = v.ack; ena = v.ena;
      if (r == v.reps - 1) sb.push_back(v);
      @(posedge clk);
      #1;
      if (r == v.reps - 1) begin
        e = sb.pop_front();
        cmp_outputs(e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int c;
    vec_t rv;

    // name, trig arm ack ena, reps, state siren strobe armed cnt
    tbl.push_back(mk("a_armed",      1,1,0,1,  1, 3'd1,0,0,1,4'd0));
    tbl.push_back(mk("a_db_wait",    1,1,0,1,  3, 3'd1,0,0,1,4'd0));
    tbl.push_back(mk("a_entry",      1,1,0,1,  1, 3'd2,0,0,1,4'd0));
    tbl.push_back(mk("a_entry_end",  1,1,0,1, 15, 3'd2,0,0,1,4'd0));
    tbl.push_back(mk("a_alarm",      1,1,0,1,  1, 3'd3,1,1,1,4'd1));
    tbl.push_back(mk("a_blink_hi",   1,1,0,1,  3, 3'd3,1,1,1,4'd1));
    tbl.push_back(mk("a_blink_lo0",  1,1,0,1,  1, 3'd3,1,0,1,4'd1));
    tbl.push_back(mk("a_blink_lo3",  1,1,0,1,  3, 3'd3,1,0,1,4'd1));
    tbl.push_back(mk("a_blink_hi2",  1,1,0,1,  1, 3'd3,1,1,1,4'd1));
    tbl.push_back(mk("a_alarm_last", 1,1,0,1, 55, 3'd3,1,0,1,4'd1));
    tbl.push_back(mk("a_silenced",   1,1,0,1,  1, 3'd4,0,1,1,4'd1));
    tbl.push_back(mk("a_quiet3",     0,1,0,1,  3, 3'd4,0,1,1,4'd1));
    tbl.push_back(mk("a_quiet4",     0,1,0,1,  1, 3'd4,0,1,1,4'd1));
    tbl.push_back(mk("a_rearm",      0,1,0,1,  1, 3'd1,0,0,1,4'd1));
    tbl.push_back(mk("b_glitch",     1,1,0,1,  3, 3'd1,0,0,1,4'd1));
    tbl.push_back(mk("b_gap",        0,1,0,1,  1, 3'd1,0,0,1,4'd1));
    tbl.push_back(mk("b_hold3",      1,1,0,1,  3, 3'd1,0,0,1,4'd1));
    tbl.push_back(mk("b_db_rise",    1,1,0,1,  1, 3'd1,0,0,1,4'd1));
    tbl.push_back(mk("b_entry",      1,1,0,1,  1, 3'd2,0,0,1,4'd1));
    tbl.push_back(mk("c_entry10",    1,1,0,1,  9, 3'd2,0,0,1,4'd1));
    tbl.push_back(mk("c_disarm",     1,0,0,1,  1, 3'd0,0,0,0,4'd1));
    tbl.push_back(mk("d_arm",        1,1,0,1,  1, 3'd1,0,0,1,4'd1));
    tbl.push_back(mk("d_entry",      1,1,0,1,  1, 3'd2,0,0,1,4'd1));
    tbl.push_back(mk("d_entry_ack",  1,1,1,1,  4, 3'd2,0,0,1,4'd1));
    tbl.push_back(mk("d_frozen",     1,0,1,0, 10, 3'd2,0,0,1,4'd1));
    tbl.push_back(mk("d_entry15",    1,1,0,1, 10, 3'd2,0,0,1,4'd1));
    tbl.push_back(mk("d_entry16",    1,1,0,1,  1, 3'd2,0,0,1,4'd1));
    tbl.push_back(mk("d_alarm",      1,1,0,1,  1, 3'd3,1,1,1,4'd2));
    tbl.push_back(mk("d_alarm3",     1,1,0,1,  2, 3'd3,1,1,1,4'd2));
    tbl.push_back(mk("d_ack",        1,1,1,1,  1, 3'd4,0,1,1,4'd2));

    rst_n = 1'b0; ena = 1'b1; trig = 1'b1; arm = 1'b1; ack = 1'b0;
    repeat (3) @(negedge clk);
    cmp_outputs(mk("reset", 1,1,0,1, 1, 3'd0,0,0,0,4'd0));
    rst_n = 1'b1;

    foreach (tbl[i]) apply_row(tbl[i]);

    // Fifteen more alarms from count 2: saturates at 15 and holds; the last one is left sounding.
    c = 2;
    for (int i = 0; i < 15; i++) begin
      apply_row(mk("s_disarm", 1,0,0,1,  1, 3'd0,0,0,0,4'(c)));
      apply_row(mk("s_arm",    1,1,0,1,  1, 3'd1,0,0,1,4'(c)));
      apply_row(mk("s_entry",  1,1,0,1, 16, 3'd2,0,0,1,4'(c)));
      c = (c < 15) ? c + 1 : 15;
      apply_row(mk("s_alarm",  1,1,0,1,  1, 3'd3,1,1,1,4'(c)));
      if (i < 14) apply_row(mk("s_ack", 1,1,1,1, 1, 3'd4,0,1,1,4'(c)));
    end

    // Reset mid-alarm, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    rv = mk("async_reset", 1,1,0,1, 1, 3'd0,0,0,0,4'd0);
    cmp_outputs(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
